// File: rtl/az_sig_gen_pkg.sv
// Shared constants and state encoding for the azimuth signal generator.
package az_sig_gen_pkg;

    localparam int DEF_SIZE        = 3200;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int REV_CNT_W       = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } az_state_t;

endpackage

// File: rtl/sync_rise_detect.sv
// Multi-flop synchroniser for an asynchronous strobe, followed by a history
// flop; emits a single-cycle pulse on each synchronised rising edge.
module sync_rise_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/azimuth_signal_gen.sv
// Replays a SIZE-bit azimuth pattern, one bit per synchronised CLK tick,
// restarted by TRIG. Define AZ_SIG_GEN_REV_CNT_EN to add the REV_CNT output.
module azimuth_signal_gen
    import az_sig_gen_pkg::*;
#(
    parameter int SIZE        = DEF_SIZE,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic            SYS_CLK,
    input  logic            RST,
    input  logic            EN,
    input  logic            TRIG,
    input  logic            CLK,
    input  logic [SIZE-1:0] DATA,
    output logic            GEN_SIGNAL
`ifdef AZ_SIG_GEN_REV_CNT_EN
    ,
    output logic [REV_CNT_W-1:0] REV_CNT
`endif
);

    localparam int IDX_W = $clog2(SIZE);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SIZE - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic             clk_rise;
    logic             trig_rise;
    logic [IDX_W-1:0] idx;
    az_state_t        state;

    sync_rise_detect #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
        .clk  (SYS_CLK),
        .rst  (RST),
        .din  (CLK),
        .rise (clk_rise)
    );

    sync_rise_detect #(.SYNC_STAGES(SYNC_STAGES)) u_trig_sync (
        .clk  (SYS_CLK),
        .rst  (RST),
        .din  (TRIG),
        .rise (trig_rise)
    );

    // TRIG outranks a same-cycle CLK tick so a restart always lands on bit 0.
    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            idx        <= '0;
            GEN_SIGNAL <= 1'b0;
`ifdef AZ_SIG_GEN_REV_CNT_EN
            REV_CNT    <= '0;
`endif
        end else if (!EN) begin
            state      <= ST_IDLE;
            idx        <= '0;
            GEN_SIGNAL <= 1'b0;
`ifdef AZ_SIG_GEN_REV_CNT_EN
            REV_CNT    <= '0;
`endif
        end else if (trig_rise) begin
            state      <= ST_RUN;
            idx        <= IDX_ONE;
            GEN_SIGNAL <= DATA[0];
        end else if (clk_rise && state == ST_RUN) begin
            GEN_SIGNAL <= DATA[idx];
            if (idx == IDX_LAST) begin
                idx <= '0;
`ifdef AZ_SIG_GEN_REV_CNT_EN
                REV_CNT <= REV_CNT + 1'b1;
`endif
            end else begin
                idx <= idx + IDX_ONE;
            end
        end
    end

endmodule

// File: tb/tb_azimuth_signal_gen.sv
// Directed bench for azimuth_signal_gen: stimulus pushes expected output values
// with their due cycle into a scoreboard; a negedge monitor pops and compares.
module tb_azimuth_signal_gen;

    localparam int SIZE = 3200;
    localparam int HALF = 1600;

    logic            SYS_CLK = 1'b0;
    logic            RST     = 1'b1;
    logic            EN      = 1'b1;
    logic            TRIG    = 1'b0;
    logic            CLK     = 1'b0;
    logic [SIZE-1:0] DATA;
    logic            GEN_SIGNAL;
    logic [15:0]     rev_val;
`ifdef AZ_SIG_GEN_REV_CNT_EN
    logic [15:0]     REV_CNT;
    assign rev_val = REV_CNT;
`else
    assign rev_val = 16'd0;
`endif

    azimuth_signal_gen #(.SIZE(SIZE), .SYNC_STAGES(2)) dut (
        .SYS_CLK    (SYS_CLK),
        .RST        (RST),
        .EN         (EN),
        .TRIG       (TRIG),
        .CLK        (CLK),
        .DATA       (DATA),
        .GEN_SIGNAL (GEN_SIGNAL)
`ifdef AZ_SIG_GEN_REV_CNT_EN
        ,
        .REV_CNT    (REV_CNT)
`endif
    );

    initial DATA = {{HALF{1'b0}}, {HALF{1'b1}}};

    always #10 SYS_CLK = ~SYS_CLK;

    int cyc = 0;
    always @(posedge SYS_CLK) cyc <= cyc + 1;

    typedef struct {
        int          due;
        bit          is_rev;
        logic [15:0] exp;
        string       tag;
    } chk_t;

    chk_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // reference state: expected output, next bit index, running flag, revolutions
    bit   m_out = 1'b0;
    int   m_idx = 0;
    bit   m_run = 1'b0;
    int   m_rev = 0;

    function automatic void expect_at(int due, bit is_rev, logic [15:0] v, string tag);
        chk_t c;
        c.due    = due;
        c.is_rev = is_rev;
        c.exp    = v;
        c.tag    = tag;
        sb.push_back(c);
    endfunction

    initial forever begin
        @(negedge SYS_CLK);
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            chk_t        c;
            logic [15:0] act;
            c   = sb.pop_front();
            act = c.is_rev ? rev_val : {15'b0, GEN_SIGNAL};
            checks++;
            if (c.due != cyc || act !== c.exp) begin
                errors++;
                $display("FAIL %s due=%0d cyc=%0d got %0d want %0d",
                         c.tag, c.due, cyc, act, c.exp);
            end
        end
    end

    function automatic void model_reset();
        m_out = 1'b0;
        m_idx = 0;
        m_run = 1'b0;
        m_rev = 0;
    endfunction

    // one CLK tick: high for two SYS_CLK periods, then low
    task automatic tick();
        @(posedge SYS_CLK); #2;
        CLK = 1'b1;
        if (EN && m_run) begin
            m_out = (m_idx < HALF);
            if (m_idx == SIZE - 1) begin
                m_idx = 0;
                m_rev = (m_rev + 1) & 16'hFFFF;
            end else begin
                m_idx++;
            end
        end
        expect_at(cyc + 3, 1'b0, {15'b0, m_out}, "tick");
        @(posedge SYS_CLK);
        @(posedge SYS_CLK); #2;
        CLK = 1'b0;
        @(posedge SYS_CLK);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic trig();
        @(posedge SYS_CLK); #2;
        TRIG = 1'b1;
        expect_at(cyc + 2, 1'b0, {15'b0, m_out}, "trig_early");
        if (EN) begin
            m_out = 1'b1;
            m_idx = 1;
            m_run = 1'b1;
        end
        expect_at(cyc + 3, 1'b0, {15'b0, m_out}, "trig");
        repeat (5) @(posedge SYS_CLK);
        #2 TRIG = 1'b0;
        @(posedge SYS_CLK);
    endtask

    task automatic trig_and_tick();
        @(posedge SYS_CLK); #2;
        TRIG = 1'b1;
        CLK  = 1'b1;
        m_out = 1'b1;
        m_idx = 1;
        m_run = 1'b1;
        expect_at(cyc + 3, 1'b0, 16'd1, "trig_clk_same");
        @(posedge SYS_CLK);
        @(posedge SYS_CLK); #2;
        TRIG = 1'b0;
        CLK  = 1'b0;
        @(posedge SYS_CLK);
    endtask

    task automatic drop_en();
        @(posedge SYS_CLK); #2;
        EN = 1'b0;
        expect_at(cyc, 1'b0, {15'b0, m_out}, "en_pre");
        model_reset();
        expect_at(cyc + 1, 1'b0, 16'd0, "en_low");
        repeat (2) @(posedge SYS_CLK);
    endtask

    task automatic async_reset();
        @(posedge SYS_CLK); #2;
        RST = 1'b1;
        model_reset();
        expect_at(cyc, 1'b0, 16'd0, "async_rst");
`ifdef AZ_SIG_GEN_REV_CNT_EN
        expect_at(cyc, 1'b1, 16'd0, "rev_rst");
`endif
        repeat (3) @(posedge SYS_CLK);
        #2 RST = 1'b0;
    endtask

    initial begin
        @(posedge SYS_CLK); #2;
        expect_at(cyc, 1'b0, 16'd0, "reset");
        repeat (4) @(posedge SYS_CLK);
        #2 RST = 1'b0;
        model_reset();

        ticks(12);              // idle: no TRIG, output must stay 0

        trig();                 // full revolution incl. wrap tick 3200
        ticks(3201);

        trig();                 // run into the zero half, then retrigger
        ticks(2000);
        trig();
        ticks(1601);

        trig();                 // enable drop mid-run
        ticks(500);
        drop_en();
        ticks(3);
        @(posedge SYS_CLK); #2 EN = 1'b1;
        ticks(5);
        trig();
        ticks(2);

        trig_and_tick();        // TRIG wins: 1->0 must land exactly on tick 1600
        ticks(1601);

        trig();                 // async reset while output is 1
        ticks(1000);
        async_reset();
        ticks(5);

        trig();
`ifdef AZ_SIG_GEN_REV_CNT_EN
        ticks(6400);
        @(posedge SYS_CLK); #2;
        expect_at(cyc, 1'b1, 16'd2, "rev_two_wraps");
`else
        ticks(3);
`endif

        repeat (6) @(posedge SYS_CLK);
        @(negedge SYS_CLK);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
